// File: rtl/otter_mmio_ctrl.sv
// rtl/otter_mmio_ctrl.sv - OTTER MMIO controller: switches, LEDs, compare timer, UART TX
// Read data on IO_IN is combinational; all state sits behind an async active-high reset.
module otter_mmio_ctrl #(
  parameter int TMR_DIV  = 4,
  parameter int BAUD_DIV = 868
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IO_ADDR,
  input  logic        IO_WR,
  input  logic [31:0] IO_DATA,
  output logic [31:0] IO_IN,
  input  logic [15:0] SWITCHES,
  output logic [15:0] LEDS,
  output logic        TX,
  output logic        INTR
);
  localparam logic [31:0] A_SW    = 32'h1100_0000;
  localparam logic [31:0] A_LED   = 32'h1100_0020;
  localparam logic [31:0] A_TCNT  = 32'h1100_0040;
  localparam logic [31:0] A_TCMP  = 32'h1100_0044;
  localparam logic [31:0] A_TCTL  = 32'h1100_0048;
  localparam logic [31:0] A_UTX   = 32'h1100_0060;
  localparam logic [31:0] A_USTAT = 32'h1100_0064;

  localparam int PW = (TMR_DIV > 1) ? $clog2(TMR_DIV) : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TMR_DIV - 1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [15:0]   r_sw_meta, r_sw_sync, r_leds;
  logic [31:0]   r_tcnt, r_tcmp;
  logic          r_en, r_autoclr, r_pend, r_irqen;
  logic [PW-1:0] r_presc;
  uart_state_t   r_state, w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_ovr;

  logic w_wr_led, w_wr_tcnt, w_wr_tcmp, w_wr_tctl, w_wr_utx, w_wr_ustat;
  logic w_tick, w_match, w_busy, w_baud_last, w_tx;

  assign w_wr_led    = IO_WR && (IO_ADDR == A_LED);
  assign w_wr_tcnt   = IO_WR && (IO_ADDR == A_TCNT);
  assign w_wr_tcmp   = IO_WR && (IO_ADDR == A_TCMP);
  assign w_wr_tctl   = IO_WR && (IO_ADDR == A_TCTL);
  assign w_wr_utx    = IO_WR && (IO_ADDR == A_UTX);
  assign w_wr_ustat  = IO_WR && (IO_ADDR == A_USTAT);
  assign w_tick      = r_en && (r_presc == PRESC_LAST);
  assign w_match     = (r_tcnt == r_tcmp);
  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_last = (r_baud == BAUD_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_leds    <= '0;
    end else begin
      r_sw_meta <= SWITCHES;
      r_sw_sync <= r_sw_meta;
      if (w_wr_led) r_leds <= IO_DATA[15:0];
    end
  end

  // Software TCNT writes override the tick update; the match still uses the old count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tcnt    <= '0;
      r_tcmp    <= '1;
      r_en      <= 1'b0;
      r_autoclr <= 1'b0;
      r_pend    <= 1'b0;
      r_irqen   <= 1'b0;
      r_presc   <= '0;
    end else begin
      if (w_wr_tcmp) r_tcmp <= IO_DATA;
      if (w_wr_tcnt) r_tcnt <= IO_DATA;
      else if (w_tick) r_tcnt <= (w_match && r_autoclr) ? 32'd0 : r_tcnt + 32'd1;
      if (w_wr_tctl) begin
        r_en      <= IO_DATA[0];
        r_autoclr <= IO_DATA[1];
        r_irqen   <= IO_DATA[3];
      end
      if (w_tick && w_match) r_pend <= 1'b1;
      else if (w_wr_tctl && IO_DATA[2]) r_pend <= 1'b0;
      if ((w_wr_tctl && !IO_DATA[0]) || w_tick) r_presc <= '0;
      else if (r_en) r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE:  if (w_wr_utx) w_state_nxt = S_START;
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_last) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_baud_last && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP:  if (w_baud_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_baud <= '0;
        r_bit  <= '0;
        if (w_wr_utx) r_shift <= IO_DATA[7:0];
      end else if (w_baud_last) begin
        r_baud <= '0;
        if (r_state == S_DATA) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 3'd1;
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
      if (w_wr_utx && w_busy) r_ovr <= 1'b1;
      else if (w_wr_ustat && IO_DATA[1]) r_ovr <= 1'b0;
    end
  end

  always_comb begin
    IO_IN = 32'd0;
    case (IO_ADDR)
      A_SW:    IO_IN = {16'd0, r_sw_sync};
      A_LED:   IO_IN = {16'd0, r_leds};
      A_TCNT:  IO_IN = r_tcnt;
      A_TCMP:  IO_IN = r_tcmp;
      A_TCTL:  IO_IN = {28'd0, r_irqen, r_pend, r_autoclr, r_en};
      A_USTAT: IO_IN = {30'd0, r_ovr, w_busy};
      default: IO_IN = 32'd0;
    endcase
  end

  assign LEDS = r_leds;
  assign TX   = w_tx;
  assign INTR = r_pend & r_irqen;
endmodule

// File: tb/tb_otter_mmio_ctrl.sv
// tb/tb_otter_mmio_ctrl.sv - scoreboard bench for otter_mmio_ctrl against a behavioural model
// Stimulus pushes expectations into queues; a negedge monitor pops and compares.
module tb_otter_mmio_ctrl;
  localparam int TMR_DIV  = 4;
  localparam int BAUD_DIV = 4;
  localparam logic [31:0] A_SW    = 32'h1100_0000;
  localparam logic [31:0] A_LED   = 32'h1100_0020;
  localparam logic [31:0] A_TCNT  = 32'h1100_0040;
  localparam logic [31:0] A_TCMP  = 32'h1100_0044;
  localparam logic [31:0] A_TCTL  = 32'h1100_0048;
  localparam logic [31:0] A_UTX   = 32'h1100_0060;
  localparam logic [31:0] A_USTAT = 32'h1100_0064;
  localparam logic [31:0] A_NONE  = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IO_ADDR = 32'd0;
  logic        IO_WR = 1'b0;
  logic [31:0] IO_DATA = 32'd0;
  logic [15:0] SWITCHES = 16'd0;
  logic [31:0] IO_IN;
  logic [15:0] LEDS;
  logic        TX, INTR;

  otter_mmio_ctrl #(.TMR_DIV(TMR_DIV), .BAUD_DIV(BAUD_DIV)) dut (
    .CLK(CLK), .RST(RST), .IO_ADDR(IO_ADDR), .IO_WR(IO_WR), .IO_DATA(IO_DATA),
    .IO_IN(IO_IN), .SWITCHES(SWITCHES), .LEDS(LEDS), .TX(TX), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Model: register values, enabled-clock count for the prescaler, position within a frame.
  logic [15:0] m_sw_q1, m_sw_q2, m_leds;
  logic [31:0] m_tcnt, m_tcmp;
  bit          m_en, m_autoclr, m_pend, m_irqen, m_ovr;
  int          m_en_clks;
  int          m_pos;
  logic [7:0]  m_byte;

  typedef struct { logic tx; logic intr; logic [15:0] leds; } out_t;
  out_t        q_out[$];
  logic [31:0] q_rd_addr[$];
  logic [31:0] q_rd_exp[$];
  out_t        mon_e;
  logic [31:0] mon_a, mon_x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sw_q1 = 16'd0; m_sw_q2 = 16'd0; m_leds = 16'd0;
    m_tcnt = 32'd0; m_tcmp = 32'hFFFF_FFFF;
    m_en = 0; m_autoclr = 0; m_pend = 0; m_irqen = 0; m_ovr = 0;
    m_en_clks = 0; m_pos = -1; m_byte = 8'd0;
  endfunction

  function automatic bit model_tick_next();
    return m_en && ((m_en_clks % TMR_DIV) == TMR_DIV - 1);
  endfunction

  function automatic logic model_tx();
    int idx;
    if (m_pos < 0) return 1'b1;
    idx = m_pos / BAUD_DIV;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    bit busy;
    busy = (m_pos >= 0);
    case (a)
      A_SW:    return {16'd0, m_sw_q2};
      A_LED:   return {16'd0, m_leds};
      A_TCNT:  return m_tcnt;
      A_TCMP:  return m_tcmp;
      A_TCTL:  return {28'd0, m_irqen, m_pend, m_autoclr, m_en};
      A_USTAT: return {30'd0, m_ovr, busy};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step();
    bit tick, match, busy, wr;
    logic [31:0] a, d;
    if (RST) begin model_reset(); return; end
    wr = IO_WR; a = IO_ADDR; d = IO_DATA;
    tick = model_tick_next();
    match = (m_tcnt == m_tcmp);
    busy = (m_pos >= 0);
    m_sw_q2 = m_sw_q1;
    m_sw_q1 = SWITCHES;
    if (wr && a == A_LED) m_leds = d[15:0];
    if (wr && a == A_TCMP) m_tcmp = d;
    if (wr && a == A_TCNT) m_tcnt = d;
    else if (tick) m_tcnt = (match && m_autoclr) ? 32'd0 : m_tcnt + 32'd1;
    if (tick && match) m_pend = 1;
    else if (wr && a == A_TCTL && d[2]) m_pend = 0;
    if (wr && a == A_TCTL && !d[0]) m_en_clks = 0;
    else if (m_en) m_en_clks = (m_en_clks + 1) % TMR_DIV;
    if (wr && a == A_TCTL) begin m_en = d[0]; m_autoclr = d[1]; m_irqen = d[3]; end
    if (busy) m_pos = (m_pos + 1 == 10 * BAUD_DIV) ? -1 : m_pos + 1;
    else if (wr && a == A_UTX) begin m_pos = 0; m_byte = d[7:0]; end
    if (wr && a == A_UTX && busy) m_ovr = 1;
    else if (wr && a == A_USTAT && d[1]) m_ovr = 0;
  endfunction

  function automatic out_t model_out();
    out_t e;
    e.tx = model_tx(); e.intr = m_pend & m_irqen; e.leds = m_leds;
    return e;
  endfunction

  task automatic cycle();
    @(posedge CLK);
    model_step();
    q_out.push_back(model_out());
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    IO_ADDR = a; IO_WR = 1'b0;
    q_rd_addr.push_back(a);
    q_rd_exp.push_back(model_read(a));
    cycle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IO_ADDR = a; IO_DATA = d; IO_WR = 1'b1;
    cycle();
    IO_WR = 1'b0;
  endtask

  task automatic drain_frame();
    for (int k = 0; k < 20 * BAUD_DIV && m_pos >= 0; k++) rd(A_USTAT);
  endtask

  task automatic wait_tick(input bit need_match);
    for (int k = 0; k < 64; k++) begin
      if (model_tick_next() && (!need_match || m_tcnt == m_tcmp)) break;
      rd(A_TCNT);
    end
  endtask

  always @(negedge CLK) begin
    if (q_out.size() > 0) begin
      mon_e = q_out.pop_front();
      check("TX", {31'd0, TX}, {31'd0, mon_e.tx});
      check("INTR", {31'd0, INTR}, {31'd0, mon_e.intr});
      check("LEDS", {16'd0, LEDS}, {16'd0, mon_e.leds});
    end
    if (q_rd_exp.size() > 0) begin
      mon_a = q_rd_addr.pop_front();
      mon_x = q_rd_exp.pop_front();
      check($sformatf("RD_%08h", mon_a), IO_IN, mon_x);
    end
  end

  initial begin
    logic [31:0] a, d;
    model_reset();
    RST = 1'b1;
    repeat (3) cycle();
    RST = 1'b0;
    SWITCHES = 16'hA5C3;
    repeat (3) rd(A_SW);
    rd(A_LED); rd(A_TCNT); rd(A_TCMP); rd(A_TCTL); rd(A_USTAT); rd(A_UTX); rd(A_NONE);

    wr(A_LED, 32'hDEAD_BEEF);
    rd(A_LED);
    wr(A_SW, 32'h0000_FFFF);
    rd(A_SW);

    wr(A_TCMP, 32'd3);
    wr(A_TCNT, 32'd0);
    wr(A_TCTL, 32'hB);
    repeat (20) rd(A_TCNT);
    rd(A_TCTL);
    wr(A_TCTL, 32'hF);
    rd(A_TCTL);
    wait_tick(1'b1);
    wr(A_TCTL, 32'hF);
    rd(A_TCTL);
    wait_tick(1'b0);
    wr(A_TCNT, 32'h100);
    rd(A_TCNT);

    wr(A_TCTL, 32'h4);
    wr(A_TCMP, 32'd5);
    wr(A_TCNT, 32'hFFFF_FFFF);
    wr(A_TCTL, 32'h1);
    repeat (8) rd(A_TCNT);
    rd(A_TCTL);

    wr(A_UTX, 32'h0000_00A5);
    repeat (12) rd(A_USTAT);
    wr(A_UTX, 32'h0000_003C);
    drain_frame();
    rd(A_USTAT);
    wr(A_USTAT, 32'h2);
    rd(A_USTAT);
    wr(A_UTX, 32'h0000_005A);
    drain_frame();
    wr(A_UTX, 32'h0000_0081);
    rd(A_USTAT);

    drain_frame();
    wr(A_UTX, 32'h0000_0096);
    for (int k = 0; k < 100 && m_pos != 4 * BAUD_DIV + 1; k++) rd(A_USTAT);
    RST = 1'b1;
    model_reset();
    if (q_out.size() > 0) void'(q_out.pop_back());
    q_out.push_back(model_out());
    IO_ADDR = A_USTAT;
    q_rd_addr.push_back(A_USTAT);
    q_rd_exp.push_back(model_read(A_USTAT));
    cycle();
    RST = 1'b0;
    rd(A_TCMP);
    wr(A_UTX, 32'h0000_003C);
    drain_frame();
    rd(A_USTAT);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: a = A_SW;    1: a = A_LED;  2: a = A_TCNT;  3: a = A_TCMP;
        4: a = A_TCTL;  5: a = A_UTX;  6: a = A_USTAT; default: a = A_NONE;
      endcase
      d = $urandom();
      if (a == A_TCNT || a == A_TCMP) d = (($urandom_range(0, 3) == 0) ? d : 32'($urandom_range(0, 6)));
      if ($urandom_range(0, 7) == 0) SWITCHES = 16'($urandom());
      if ($urandom_range(0, 2) == 0) wr(a, d);
      else rd(a);
    end
    drain_frame();
    rd(A_USTAT);

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
